mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported `memory32` instance between the processor's instruction-fetch requester and its data load/store requester, so a unified program/data RAM can serve both. Requests are arbitrated round-robin, checked for word alignment, and issued one at a time. Responses, with RISC-V exception codes, are returned on per-requester valid/ready channels. The block sits between the processor core and the RAM inside the system model.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; fixed at 32 to match `memory32`

Ports:
- clk  input  1  system clock; the block uses this single clock
- reset  input  1  synchronous, active-high reset
- fetch_req_valid  input  1  fetch request present
- fetch_req_ready  output  1  fetch request accepted this cycle
- fetch_req_addr  input  ADDR_W  fetch byte address
- fetch_res_valid  output  1  fetch response present
- fetch_res_ready  input  1  fetch response consumed
- fetch_res_data  output  DATA_W  instruction word
- fetch_res_exc_valid  output  1  exception flag for the fetch response
- fetch_res_exc_code  output  4  exception cause
- data_req_valid  input  1  data request present
- data_req_ready  output  1  data request accepted this cycle
- data_req_we  input  1  1 = store, 0 = load
- data_req_addr  input  ADDR_W  data byte address
- data_req_wdata  input  DATA_W  store data
- data_res_valid, data_res_ready, data_res_data, data_res_exc_valid, data_res_exc_code: same meaning as the fetch response ports
- mem_en  output  1  memory access strobe, 1 cycle
- mem_we  output  1  write enable, qualified by mem_en
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  write data
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_en
- mem_exc  input  1  memory fault, valid with mem_rdata

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. The block allows one transaction in flight.
- IDLE: the arbiter picks one valid requester. Only the winner sees ready=1. The block latches the winner's id, we, addr and wdata, then moves to ISSUE.
- Arbitration: round-robin on a `last_grant` bit. If both requesters are valid, the one not granted last wins. If only one is valid, it wins.
- ISSUE: if addr[1:0]==0, the block drives mem_en=1 with the latched fields. If misaligned, the memory is not touched (mem_en=0) and the exception code is set to 0 for fetch, 4 for a load, or 6 for a store.
- WAIT: the block captures mem_rdata and mem_exc. A mem_exc maps to code 1 for fetch, 5 for a load, or 7 for a store.
- RESP: the winner's res_valid is held with its data and exception fields until res_ready=1. The FSM then returns to IDLE.
- Store responses return data=0. A store response is the write acknowledgement.
- Outputs are registered. Response fields are stable while res_valid=1.

## Timing
- Reset values: every *_ready, *_res_valid, *_exc_valid, mem_en and mem_we are 0. All data, address and code outputs are 0. The FSM is in IDLE. last_grant=data, so fetch wins the first tie.
- Latency: a request accepted in cycle N drives mem_en in N+1, captures mem_rdata at the end of N+2, and asserts res_valid in N+3.
- Throughput: with res_ready tied high, one transaction every 4 cycles.
- Simultaneous requests in IDLE: exactly one ready goes high. The loser keeps its valid asserted and is served next.
- Backpressure: if res_ready=0 the FSM stays in RESP, and no new request is accepted.
- Reset in any state: the FSM returns to IDLE on the next edge. An in-flight response is dropped. A store already issued in ISSUE stays written.
- A requester must hold valid and its fields stable until ready. The block does not check this.

## Structure
- Shared package `mem_arb_pkg`:
  - the state enum
  - the exception cause constants (0, 1, 4, 5, 6, 7)
  - the packed `mem_req_t` {we, addr, wdata}
  - the packed `mem_res_t` {data, exc_valid, exc_code}
- Sub-module `rr_arbiter2`: 2-input round-robin arbiter with a one-hot grant, updating `last_grant` on accept.

## Test plan
- Fetch only, addr 0x100, mem_rdata=0x00000013 -> mem_en in N+1; fetch_res_valid in N+3 with data 0x00000013 and exc_valid=0.
- Fetch and load both valid at reset release -> fetch granted first, then the load. A third tie grants fetch again.
- Store to 0x204, data 0xDEADBEEF -> mem_we=1, mem_addr=0x204, mem_wdata=0xDEADBEEF for 1 cycle. data_res_valid with data 0.
- Load from 0x203 -> mem_en stays 0; data_res exc_valid=1, code 4. Fetch from 0x102 -> code 0.
- data_res_ready held 0 for 5 cycles while fetch_req_valid=1 -> response stays stable and fetch_req_ready stays 0 until release.
- Reset asserted in WAIT -> next cycle all outputs are 0 and the FSM is in IDLE. No response is produced for the dropped request.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Exception causes use the RISC-V mcause encodings.
package mem_arb_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
   localparam logic [3:0] EXC_INSTR_FAULT      = 4'd1;
   localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
   localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA  = 1'b1;

   typedef struct packed {
      logic                  we;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic [ARB_DATA_W-1:0] data;
      logic                  exc_valid;
      logic [3:0]            exc_code;
   } mem_res_t;

   // fault=0 selects the misaligned cause, fault=1 the access-fault cause
   function automatic logic [3:0] exc_cause(input logic id, input logic we, input logic fault);
      if (id == REQ_FETCH)
         return fault ? EXC_INSTR_FAULT : EXC_INSTR_MISALIGNED;
      else if (we)
         return fault ? EXC_STORE_FAULT : EXC_STORE_MISALIGNED;
      else
         return fault ? EXC_LOAD_FAULT : EXC_LOAD_MISALIGNED;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with one-hot grant; bit 0 = fetch, bit 1 = data.
// last_grant remembers the most recently accepted requester.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      if (req[0] && req[1])
         grant = (last_grant == REQ_DATA) ? 2'b01 : 2'b10;
      else
         grant = req;
   end

   // Reset to data so that fetch wins the first tie
   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= REQ_DATA;
      else if (accept && (grant != 2'b00))
         last_grant <= grant[1];
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 32-bit memory between instruction fetch and data load/store.
// One transaction in flight; responses carry RISC-V exception causes.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | arbitrate, accept one request and latch its fields
//   ST_ISSUE | drive the memory strobe (suppressed for misaligned addr)
//   ST_WAIT  | capture mem_rdata / mem_exc into the response register
//   ST_RESP  | hold the response on the winner's channel until consumed
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              fetch_req_valid,
   output logic              fetch_req_ready,
   input  logic [ADDR_W-1:0] fetch_req_addr,
   output logic              fetch_res_valid,
   input  logic              fetch_res_ready,
   output logic [DATA_W-1:0] fetch_res_data,
   output logic              fetch_res_exc_valid,
   output logic [3:0]        fetch_res_exc_code,

   input  logic              data_req_valid,
   output logic              data_req_ready,
   input  logic              data_req_we,
   input  logic [ADDR_W-1:0] data_req_addr,
   input  logic [DATA_W-1:0] data_req_wdata,
   output logic              data_res_valid,
   input  logic              data_res_ready,
   output logic [DATA_W-1:0] data_res_data,
   output logic              data_res_exc_valid,
   output logic [3:0]        data_res_exc_code,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_exc
);

   arb_state_e state, state_nxt;

   logic [1:0] grant;
   logic       accept;
   logic       id_q;
   mem_req_t   req_q, req_in;
   mem_res_t   res_q, res_nxt;
   logic       aligned_q;
   logic       res_ready_sel;
   logic       issue_go;
   logic       resp_fetch, resp_data;

   rr_arbiter2 u_rr (
      .clk    (clk),
      .reset  (reset),
      .req    ({data_req_valid, fetch_req_valid}),
      .accept (accept),
      .grant  (grant)
   );

   // Ready is only offered in IDLE and never while reset is held
   assign accept          = (state == ST_IDLE) && !reset && (grant != 2'b00);
   assign fetch_req_ready = accept && grant[0];
   assign data_req_ready  = accept && grant[1];

   assign aligned_q     = (req_q.addr[1:0] == 2'b00);
   assign res_ready_sel = (id_q == REQ_DATA) ? data_res_ready : fetch_res_ready;

   always_comb begin
      req_in = '0;
      if (grant[1]) begin
         req_in.we    = data_req_we;
         req_in.addr  = data_req_addr;
         req_in.wdata = data_req_wdata;
      end else begin
         req_in.addr  = fetch_req_addr;
      end
   end

   always_comb begin
      res_nxt = '0;
      if (!aligned_q) begin
         res_nxt.exc_valid = 1'b1;
         res_nxt.exc_code  = exc_cause(id_q, req_q.we, 1'b0);
      end else if (mem_exc) begin
         res_nxt.exc_valid = 1'b1;
         res_nxt.exc_code  = exc_cause(id_q, req_q.we, 1'b1);
      end else if (!req_q.we) begin
         res_nxt.data = mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_RESP;
         ST_RESP:  if (res_ready_sel) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_q  <= REQ_FETCH;
         req_q <= '0;
         res_q <= '0;
      end else begin
         if (accept) begin
            id_q  <= grant[1];
            req_q <= req_in;
         end
         if (state == ST_WAIT)
            res_q <= res_nxt;
      end
   end

   // Outputs decode only registered state, so they are glitch-free and stable in RESP
   always_comb begin
      issue_go   = (state == ST_ISSUE) && aligned_q;
      resp_fetch = (state == ST_RESP) && (id_q == REQ_FETCH);
      resp_data  = (state == ST_RESP) && (id_q == REQ_DATA);

      mem_en    = issue_go;
      mem_we    = issue_go && req_q.we;
      mem_addr  = issue_go ? req_q.addr  : '0;
      mem_wdata = issue_go ? req_q.wdata : '0;

      fetch_res_valid     = resp_fetch;
      fetch_res_data      = resp_fetch ? res_q.data      : '0;
      fetch_res_exc_valid = resp_fetch && res_q.exc_valid;
      fetch_res_exc_code  = resp_fetch ? res_q.exc_code  : 4'd0;

      data_res_valid      = resp_data;
      data_res_data       = resp_data ? res_q.data       : '0;
      data_res_exc_valid  = resp_data && res_q.exc_valid;
      data_res_exc_code   = resp_data ? res_q.exc_code   : 4'd0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses go into a queue at
// accept time and are popped when the matching res_valid appears.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req_valid, fetch_req_ready;
   logic [31:0] fetch_req_addr;
   logic        fetch_res_valid, fetch_res_ready;
   logic [31:0] fetch_res_data;
   logic        fetch_res_exc_valid;
   logic [3:0]  fetch_res_exc_code;
   logic        data_req_valid, data_req_ready, data_req_we;
   logic [31:0] data_req_addr, data_req_wdata;
   logic        data_res_valid, data_res_ready;
   logic [31:0] data_res_data;
   logic        data_res_exc_valid;
   logic [3:0]  data_res_exc_code;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_exc;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      logic        exc_valid;
      logic [3:0]  code;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk                 (clk),
      .reset               (reset),
      .fetch_req_valid     (fetch_req_valid),
      .fetch_req_ready     (fetch_req_ready),
      .fetch_req_addr      (fetch_req_addr),
      .fetch_res_valid     (fetch_res_valid),
      .fetch_res_ready     (fetch_res_ready),
      .fetch_res_data      (fetch_res_data),
      .fetch_res_exc_valid (fetch_res_exc_valid),
      .fetch_res_exc_code  (fetch_res_exc_code),
      .data_req_valid      (data_req_valid),
      .data_req_ready      (data_req_ready),
      .data_req_we         (data_req_we),
      .data_req_addr       (data_req_addr),
      .data_req_wdata      (data_req_wdata),
      .data_res_valid      (data_res_valid),
      .data_res_ready      (data_res_ready),
      .data_res_data       (data_res_data),
      .data_res_exc_valid  (data_res_exc_valid),
      .data_res_exc_code   (data_res_exc_code),
      .mem_en              (mem_en),
      .mem_we              (mem_we),
      .mem_addr            (mem_addr),
      .mem_wdata           (mem_wdata),
      .mem_rdata           (mem_rdata),
      .mem_exc             (mem_exc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input bit is_data, input bit we, input logic [31:0] addr,
                                  input logic [31:0] rdata, input bit fault);
      exp_t e;
      e.data = 32'h0; e.exc_valid = 1'b0; e.code = 4'd0;
      if (addr[1:0] != 2'b00) begin
         e.exc_valid = 1'b1;
         e.code = !is_data ? 4'd0 : (we ? 4'd6 : 4'd4);
      end else if (fault) begin
         e.exc_valid = 1'b1;
         e.code = !is_data ? 4'd1 : (we ? 4'd7 : 4'd5);
      end else if (!is_data || !we) begin
         e.data = rdata;
      end
      return e;
   endfunction

   task automatic do_txn(input bit is_data, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input bit fault, input int hold);
      string nm;
      int    n;
      exp_t  e, got;
      logic  own_rdy, own_vld;
      nm = is_data ? (we ? "store" : "load") : "fetch";
      if (is_data) begin
         data_req_valid = 1'b1; data_req_we = we; data_req_addr = addr; data_req_wdata = wdata;
      end else begin
         fetch_req_valid = 1'b1; fetch_req_addr = addr;
      end
      #1;
      n = 0;
      own_rdy = is_data ? data_req_ready : fetch_req_ready;
      while (!own_rdy && n < 20) begin
         tick();
         n++;
         own_rdy = is_data ? data_req_ready : fetch_req_ready;
      end
      chkb({nm, "_grant"}, own_rdy, 1'b1);
      if (!own_rdy) begin
         if (is_data) data_req_valid = 1'b0; else fetch_req_valid = 1'b0;
         return;
      end
      chkb({nm, "_loser_ready"}, is_data ? fetch_req_ready : data_req_ready, 1'b0);
      sb.push_back(model(is_data, we, addr, rdata, fault));

      tick();  // ISSUE
      if (is_data) data_req_valid = 1'b0; else fetch_req_valid = 1'b0;
      if (addr[1:0] == 2'b00) begin
         chkb({nm, "_mem_en"}, mem_en, 1'b1);
         chkb({nm, "_mem_we"}, mem_we, we);
         chk({nm, "_mem_addr"}, mem_addr, addr);
         if (we) chk({nm, "_mem_wdata"}, mem_wdata, wdata);
      end else begin
         chkb({nm, "_misaligned_mem_en"}, mem_en, 1'b0);
      end
      chk({nm, "_issue_readies"}, 32'({fetch_req_ready, data_req_ready}), 32'd0);
      mem_rdata = rdata;
      mem_exc   = fault;
      if (is_data) data_res_ready = (hold == 0); else fetch_res_ready = (hold == 0);

      tick();  // WAIT
      chkb({nm, "_wait_mem_en"}, mem_en, 1'b0);
      chkb({nm, "_wait_res_valid"}, is_data ? data_res_valid : fetch_res_valid, 1'b0);

      tick();  // RESP
      own_vld = is_data ? data_res_valid : fetch_res_valid;
      chkb({nm, "_res_valid"}, own_vld, 1'b1);
      chkb({nm, "_other_res_valid"}, is_data ? fetch_res_valid : data_res_valid, 1'b0);
      if (own_vld && sb.size() > 0) begin
         got = sb.pop_front();
         e = got;
         chk({nm, "_res_data"}, is_data ? data_res_data : fetch_res_data, e.data);
         chkb({nm, "_res_exc_valid"}, is_data ? data_res_exc_valid : fetch_res_exc_valid, e.exc_valid);
         chk({nm, "_res_exc_code"}, 32'(is_data ? data_res_exc_code : fetch_res_exc_code), 32'(e.code));
         for (int i = 0; i < hold; i++) begin
            tick();
            chkb({nm, "_hold_valid"}, is_data ? data_res_valid : fetch_res_valid, 1'b1);
            chk({nm, "_hold_data"}, is_data ? data_res_data : fetch_res_data, e.data);
            chk({nm, "_hold_code"}, 32'(is_data ? data_res_exc_code : fetch_res_exc_code), 32'(e.code));
            chk({nm, "_hold_readies"}, 32'({fetch_req_ready, data_req_ready}), 32'd0);
         end
      end
      data_res_ready  = 1'b1;
      fetch_res_ready = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      mem_exc   = 1'b0;
      tick();  // back to IDLE
      chkb({nm, "_res_released"}, is_data ? data_res_valid : fetch_res_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      fetch_req_valid = 1'b0; fetch_req_addr = 32'h0; fetch_res_ready = 1'b1;
      data_req_valid = 1'b0; data_req_we = 1'b0; data_req_addr = 32'h0; data_req_wdata = 32'h0;
      data_res_ready = 1'b1;
      mem_rdata = 32'h0; mem_exc = 1'b0;
      repeat (3) tick();

      chkb("rst_mem_en", mem_en, 1'b0);
      chkb("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chkb("rst_fetch_res_valid", fetch_res_valid, 1'b0);
      chkb("rst_data_res_valid", data_res_valid, 1'b0);
      chk("rst_fetch_res_data", fetch_res_data, 32'h0);
      chk("rst_data_res_data", data_res_data, 32'h0);

      // both requesters present while reset is still held: no ready may appear
      fetch_req_valid = 1'b1; fetch_req_addr = 32'h100;
      data_req_valid = 1'b1; data_req_we = 1'b0; data_req_addr = 32'h200;
      #1;
      chk("rst_readies", 32'({fetch_req_ready, data_req_ready}), 32'd0);
      tick();
      reset = 1'b0;

      // first tie after reset goes to fetch, then the waiting load
      do_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'h00000013, 1'b0, 0);
      do_txn(1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE0001, 1'b0, 0);
      // third tie: fetch again
      data_req_valid = 1'b1; data_req_we = 1'b0; data_req_addr = 32'h208;
      do_txn(1'b0, 1'b0, 32'h104, 32'h0, 32'h00500093, 1'b0, 0);
      do_txn(1'b1, 1'b0, 32'h208, 32'h0, 32'h000000A5, 1'b0, 0);

      do_txn(1'b1, 1'b1, 32'h204, 32'hDEADBEEF, 32'h12345678, 1'b0, 0);
      do_txn(1'b1, 1'b0, 32'h203, 32'h0, 32'h55555555, 1'b0, 0);
      do_txn(1'b0, 1'b0, 32'h102, 32'h0, 32'h66666666, 1'b0, 0);
      do_txn(1'b1, 1'b1, 32'h206, 32'h01020304, 32'h0, 1'b0, 0);
      do_txn(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1, 0);
      do_txn(1'b1, 1'b1, 32'h304, 32'hA5A5A5A5, 32'h0, 1'b1, 0);
      do_txn(1'b0, 1'b0, 32'h108, 32'h0, 32'h0, 1'b1, 0);

      // backpressure on the data channel with fetch waiting
      fetch_req_valid = 1'b1; fetch_req_addr = 32'h10C;
      do_txn(1'b1, 1'b0, 32'h210, 32'h0, 32'h0BADF00D, 1'b0, 5);
      do_txn(1'b0, 1'b0, 32'h10C, 32'h0, 32'h00000073, 1'b0, 0);

      // reset while a fetch sits in WAIT
      fetch_req_valid = 1'b1; fetch_req_addr = 32'h140;
      #1;
      n = 0;
      while (!fetch_req_ready && n < 20) begin tick(); n++; end
      chkb("rstwait_grant", fetch_req_ready, 1'b1);
      tick();
      fetch_req_valid = 1'b0;
      mem_rdata = 32'h11111111;
      tick();
      reset = 1'b1;
      tick();
      chkb("rstwait_mem_en", mem_en, 1'b0);
      chk("rstwait_mem_addr", mem_addr, 32'h0);
      chkb("rstwait_fetch_res_valid", fetch_res_valid, 1'b0);
      chk("rstwait_fetch_res_data", fetch_res_data, 32'h0);
      chkb("rstwait_fetch_exc_valid", fetch_res_exc_valid, 1'b0);
      chk("rstwait_readies", 32'({fetch_req_ready, data_req_ready}), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rstwait_no_resp", 32'({fetch_res_valid, data_res_valid}), 32'd0);
      end

      // last_grant returned to data by reset, so fetch wins this tie
      data_req_valid = 1'b1; data_req_we = 1'b0; data_req_addr = 32'h220;
      do_txn(1'b0, 1'b0, 32'h110, 32'h0, 32'h00100093, 1'b0, 0);
      do_txn(1'b1, 1'b0, 32'h220, 32'h0, 32'h76543210, 1'b0, 0);

      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
